complex_div: RTL
================

Name: complex_div

Overview:
- Iterative signed complex divider: q = a / b.
- Inverse operation of the complex multiplier in the datapath. Used where equalisation or normalisation needs a quotient rather than a product.
- Valid/ready on both sides; one division in flight at a time.
- Fixed latency, independent of operand values.

Parameters:
- WIDTH, 8, bit width of each signed two's-complement input component.
- FRAC, 7, number of fractional bits in each quotient component.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  block can accept operands (IDLE only).
- a_real_i  input  WIDTH  dividend real part, signed.
- a_imag_i  input  WIDTH  dividend imaginary part, signed.
- b_real_i  input  WIDTH  divisor real part, signed.
- b_imag_i  input  WIDTH  divisor imaginary part, signed.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- q_real_o  output  WIDTH+FRAC+1  quotient real part, signed, FRAC fractional bits.
- q_imag_o  output  WIDTH+FRAC+1  quotient imaginary part, signed, FRAC fractional bits.
- dbz_o  output  1  divide-by-zero flag, qualified by out_valid_o.

Behaviour:
- Reset (async, rst_n_i low), all outputs:
  - in_ready_o=1, out_valid_o=0, q_real_o=0, q_imag_o=0, dbz_o=0.
  - FSM in IDLE; internal registers cleared.
- Reset asserted mid-operation aborts the division immediately; no partial result is ever presented.
- FSM states: IDLE, PREP, DIV, DONE.
  - IDLE -> PREP on in_valid_i & in_ready_o; operands captured at that edge.
  - PREP (1 cycle) registers:
    - nr = ar*br + ai*bi, signed, 2*WIDTH+1 bits.
    - ni = ai*br - ar*bi, signed, 2*WIDTH+1 bits.
    - den = br*br + bi*bi, unsigned, 2*WIDTH bits.
    - Sign of each numerator and |nr|, |ni|.
  - PREP -> DIV.
  - DIV: |nr|<<FRAC and |ni|<<FRAC divided by den in parallel, restoring, one quotient bit per cycle.
    - N = 2*WIDTH+FRAC+1 cycles; iteration counter counts 0..N-1.
  - DIV -> DONE after iteration N-1. On that edge:
    - Numerator signs are applied (truncation toward zero).
    - Quotients are truncated to WIDTH+FRAC+1 bits. This is lossless: |q| <= 2^(WIDTH-1) for all legal operands, so no saturation logic.
    - q_*_o and out_valid_o are registered.
  - DONE: outputs held stable while out_ready_i=0. DONE -> IDLE on out_ready_i=1; out_valid_o deasserts at that edge.
- Latency: out_valid_o rises N+2 cycles after the accepting edge (26 at defaults).
- Throughput: no new accept until the result is consumed; in_ready_o=1 only in IDLE.
  - Result consumed at edge t -> in_ready_o=1 in the cycle after t.
  - No same-cycle consume+accept.
- Divide by zero (b = 0+0j):
  - Full latency is still spent; DIV iterations are allowed to run.
  - Reported result is q_real_o=0, q_imag_o=0, dbz_o=1.
  - dbz_o=0 for every other result.
- a = 0: the result is 0+0j with dbz_o=0.
- in_valid_i while busy is ignored; operand inputs are not sampled outside the IDLE accept edge.

Decomposition:
- Shared package/header holds:
  - FSM state encodings.
  - Derived localparams: NUM_W = 2*WIDTH+1, DEN_W = 2*WIDTH, DIVD_W = NUM_W+FRAC, Q_W = WIDTH+FRAC+1, N.
- Sub-module seq_udiv: unsigned restoring divider step engine.
  - Inputs: start, dividend DIVD_W, divisor DEN_W.
  - Outputs: quotient DIVD_W.
  - Instantiated twice (real, imag) and driven by the common counter in complex_div.

Test Plan (WIDTH=8, FRAC=7):
- (6+8j)/(3+4j) -> q_real_o=256, q_imag_o=0, dbz_o=0, out_valid_o exactly 26 cycles after accept.
- (1+0j)/(0+1j) -> q_real_o=0, q_imag_o=-128; (1+1j)/(3+0j) -> 42, 42; (-1+0j)/(3+0j) -> -42, 0 (truncation toward zero).
- (-128-128j)/(1+1j) -> q_real_o=-16384, q_imag_o=0 (magnitude bound); (-128+0j)/(1+0j) -> -16384, 0.
- (5+5j)/(0+0j) -> q_real_o=0, q_imag_o=0, dbz_o=1, same latency; next op (2+0j)/(1+0j) -> 256, 0, dbz_o=0.
- out_ready_i held 0 for 10 cycles in DONE -> outputs stable, in_ready_o=0, extra in_valid_i pulses ignored; release -> one transfer, then in_ready_o=1 next cycle.
- rst_n_i pulsed low mid-DIV -> all outputs at reset values asynchronously, no out_valid_o; new operation afterwards yields correct result.

Source files
------------

// File: rtl/complex_div_pkg.sv
// Shared widths and FSM encoding for the iterative complex divider.
package complex_div_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned FRAC   = 7;
  localparam int unsigned NUM_W  = 2 * WIDTH + 1;
  localparam int unsigned DEN_W  = 2 * WIDTH;
  localparam int unsigned DIVD_W = NUM_W + FRAC;
  localparam int unsigned Q_W    = WIDTH + FRAC + 1;
  localparam int unsigned N      = 2 * WIDTH + FRAC + 1;
  // Counter spans the N restoring steps plus one result-capture slot
  localparam int unsigned CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/complex_div_if.sv
// Operand/result handshake bundle for complex_div.
interface complex_div_if;
  import complex_div_pkg::*;

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic signed [WIDTH-1:0] a_real_i;
  logic signed [WIDTH-1:0] a_imag_i;
  logic signed [WIDTH-1:0] b_real_i;
  logic signed [WIDTH-1:0] b_imag_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic signed [Q_W-1:0]   q_real_o;
  logic signed [Q_W-1:0]   q_imag_o;
  logic                    dbz_o;

  modport master (
    output in_valid_i, a_real_i, a_imag_i, b_real_i, b_imag_i, out_ready_i,
    input  in_ready_o, out_valid_o, q_real_o, q_imag_o, dbz_o
  );

  modport slave (
    input  in_valid_i, a_real_i, a_imag_i, b_real_i, b_imag_i, out_ready_i,
    output in_ready_o, out_valid_o, q_real_o, q_imag_o, dbz_o
  );

endinterface

// File: rtl/complex_div_seq_udiv.sv
// Unsigned restoring divider: loads on start, produces one quotient bit per step.
module seq_udiv
  import complex_div_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start,
  input  logic              step,
  input  logic [DIVD_W-1:0] dividend,
  input  logic [DEN_W-1:0]  divisor,
  output logic [DIVD_W-1:0] quotient
);

  logic [DEN_W-1:0]  rem_q;
  logic [DEN_W-1:0]  div_q;
  logic [DIVD_W-1:0] quo_q;
  logic [DEN_W:0]    trial_c;
  logic              fits_c;

  // Dividend bits shift out of the quotient register as quotient bits shift in
  always_comb begin
    trial_c = {rem_q, quo_q[DIVD_W-1]};
    fits_c  = (trial_c >= {1'b0, div_q});
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      div_q <= divisor;
      quo_q <= dividend;
    end else if (step) begin
      if (fits_c) begin
        rem_q <= DEN_W'(trial_c - {1'b0, div_q});
        quo_q <= {quo_q[DIVD_W-2:0], 1'b1};
      end else begin
        rem_q <= trial_c[DEN_W-1:0];
        quo_q <= {quo_q[DIVD_W-2:0], 1'b0};
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/complex_div.sv
// Iterative signed complex divider q = a / b with fixed latency and valid/ready handshakes.
module complex_div
  import complex_div_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  complex_div_if.slave bus
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    accept_c, start_c, step_c, finish_c, consume_c;

  logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic                    nr_neg_q, ni_neg_q, dbz_pend_q;
  logic                    in_ready_q, out_valid_q, dbz_q;
  logic signed [Q_W-1:0]   q_real_q, q_imag_q;

  logic signed [NUM_W-1:0] p_rr, p_ii, p_ir, p_ri, p_bb, p_cc, den_sum;
  logic signed [NUM_W-1:0] nr_c, ni_c;
  logic [NUM_W-1:0]        nr_abs_c, ni_abs_c;
  logic [DEN_W-1:0]        den_c;
  logic [DIVD_W-1:0]       quo_r, quo_i;
  logic signed [Q_W-1:0]   mag_r, mag_i, q_real_c, q_imag_c;
  logic                    unused_hi;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_c  = 1'b0;
    start_c   = 1'b0;
    step_c    = 1'b0;
    finish_c  = 1'b0;
    consume_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i && in_ready_q) begin
          accept_c = 1'b1;
          state_d  = PREP;
        end
      end
      PREP: begin
        start_c = 1'b1;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        // Slots 0..N-1 are restoring steps; slot N captures the finished quotients
        if (cnt_q == CNT_W'(N)) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end else begin
          step_c = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          consume_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cross products and divisor energy from the captured operands
  always_comb begin
    p_rr     = NUM_W'(ar_q) * NUM_W'(br_q);
    p_ii     = NUM_W'(ai_q) * NUM_W'(bi_q);
    p_ir     = NUM_W'(ai_q) * NUM_W'(br_q);
    p_ri     = NUM_W'(ar_q) * NUM_W'(bi_q);
    p_bb     = NUM_W'(br_q) * NUM_W'(br_q);
    p_cc     = NUM_W'(bi_q) * NUM_W'(bi_q);
    nr_c     = p_rr + p_ii;
    ni_c     = p_ir - p_ri;
    den_sum  = p_bb + p_cc;
    den_c    = DEN_W'(den_sum);
    nr_abs_c = nr_c[NUM_W-1] ? NUM_W'(-nr_c) : NUM_W'(nr_c);
    ni_abs_c = ni_c[NUM_W-1] ? NUM_W'(-ni_c) : NUM_W'(ni_c);
  end

  seq_udiv u_div_real (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start    (start_c),
    .step     (step_c),
    .dividend ({nr_abs_c, {FRAC{1'b0}}}),
    .divisor  (den_c),
    .quotient (quo_r)
  );

  seq_udiv u_div_imag (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start    (start_c),
    .step     (step_c),
    .dividend ({ni_abs_c, {FRAC{1'b0}}}),
    .divisor  (den_c),
    .quotient (quo_i)
  );

  // Magnitude never exceeds 2^(WIDTH-1+FRAC), so the upper quotient bits are always zero
  assign unused_hi = ^{quo_r[DIVD_W-1:Q_W], quo_i[DIVD_W-1:Q_W]};
  assign mag_r     = Q_W'(quo_r);
  assign mag_i     = Q_W'(quo_i);
  assign q_real_c  = nr_neg_q ? -mag_r : mag_r;
  assign q_imag_c  = ni_neg_q ? -mag_i : mag_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      nr_neg_q    <= 1'b0;
      ni_neg_q    <= 1'b0;
      dbz_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      q_real_q    <= '0;
      q_imag_q    <= '0;
    end else begin
      if (accept_c) begin
        ar_q       <= bus.a_real_i;
        ai_q       <= bus.a_imag_i;
        br_q       <= bus.b_real_i;
        bi_q       <= bus.b_imag_i;
        in_ready_q <= 1'b0;
      end
      if (start_c) begin
        nr_neg_q   <= nr_c[NUM_W-1];
        ni_neg_q   <= ni_c[NUM_W-1];
        dbz_pend_q <= (den_c == '0);
      end
      if (finish_c) begin
        q_real_q    <= dbz_pend_q ? '0 : q_real_c;
        q_imag_q    <= dbz_pend_q ? '0 : q_imag_c;
        dbz_q       <= dbz_pend_q;
        out_valid_q <= 1'b1;
      end
      if (consume_c) begin
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.q_real_o    = q_real_q;
  assign bus.q_imag_o    = q_imag_q;
  assign bus.dbz_o       = dbz_q;

endmodule
